// File: rtl/morse_keyer.sv
// Morse keyer: letter code to J/K set/clear pulses for the line flip-flop.
// Programmable unit length; one character at a time via START/BUSY/DONE.
module morse_keyer #(
    parameter int UNIT_CYCLES = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic [4:0] CHAR,
    output logic       J,
    output logic       K,
    output logic       KEY,
    output logic       BUSY,
    output logic       DONE,
    output logic       ERR
);

    localparam int CW0 = $clog2(3 * UNIT_CYCLES);
    localparam int CW  = (CW0 < 1) ? 1 : CW0;
    localparam logic [CW-1:0] DOT_LD  = CW'(UNIT_CYCLES - 1);
    localparam logic [CW-1:0] DASH_LD = CW'(3 * UNIT_CYCLES - 1);

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        MARK,
        SPACE,
        CGAP
    } state_t;

    state_t        state, nstate;
    logic [CW-1:0] cnt, ncnt;
    logic [1:0]    idx, nidx;
    logic [3:0]    pat, npat;
    logic          nj, nk, nkey, nbusy, ndone, nerr;

    logic [2:0]    rom_len;
    logic [3:0]    rom_pat;
    logic          rom_ok;
    logic [1:0]    first_idx;
    logic [1:0]    prev_idx;

    // Letter ROM: element count and pattern (1 = dash), first element at bit len-1
    always_comb begin
        rom_len = 3'd0;
        rom_pat = 4'b0000;
        case (CHAR)
            5'd0:  begin rom_len = 3'd2; rom_pat = 4'b0001; end
            5'd1:  begin rom_len = 3'd4; rom_pat = 4'b1000; end
            5'd2:  begin rom_len = 3'd4; rom_pat = 4'b1010; end
            5'd3:  begin rom_len = 3'd3; rom_pat = 4'b0100; end
            5'd4:  begin rom_len = 3'd1; rom_pat = 4'b0000; end
            5'd5:  begin rom_len = 3'd4; rom_pat = 4'b0010; end
            5'd6:  begin rom_len = 3'd3; rom_pat = 4'b0110; end
            5'd7:  begin rom_len = 3'd4; rom_pat = 4'b0000; end
            5'd8:  begin rom_len = 3'd2; rom_pat = 4'b0000; end
            5'd9:  begin rom_len = 3'd4; rom_pat = 4'b0111; end
            5'd10: begin rom_len = 3'd3; rom_pat = 4'b0101; end
            5'd11: begin rom_len = 3'd4; rom_pat = 4'b0100; end
            5'd12: begin rom_len = 3'd2; rom_pat = 4'b0011; end
            5'd13: begin rom_len = 3'd2; rom_pat = 4'b0010; end
            5'd14: begin rom_len = 3'd3; rom_pat = 4'b0111; end
            5'd15: begin rom_len = 3'd4; rom_pat = 4'b0110; end
            5'd16: begin rom_len = 3'd4; rom_pat = 4'b1101; end
            5'd17: begin rom_len = 3'd3; rom_pat = 4'b0010; end
            5'd18: begin rom_len = 3'd3; rom_pat = 4'b0000; end
            5'd19: begin rom_len = 3'd1; rom_pat = 4'b0001; end
            5'd20: begin rom_len = 3'd3; rom_pat = 4'b0001; end
            5'd21: begin rom_len = 3'd4; rom_pat = 4'b0001; end
            5'd22: begin rom_len = 3'd3; rom_pat = 4'b0011; end
            5'd23: begin rom_len = 3'd4; rom_pat = 4'b1001; end
            5'd24: begin rom_len = 3'd4; rom_pat = 4'b1011; end
            5'd25: begin rom_len = 3'd4; rom_pat = 4'b1100; end
            default: begin rom_len = 3'd0; rom_pat = 4'b0000; end
        endcase
    end

    assign rom_ok    = (rom_len != 3'd0);
    assign first_idx = rom_len[1:0] - 2'd1;
    assign prev_idx  = idx - 2'd1;

    // Next state and next-cycle outputs; outputs are registered below
    always_comb begin
        nstate = state;
        ncnt   = cnt;
        nidx   = idx;
        npat   = pat;
        nj     = 1'b0;
        nk     = 1'b0;
        nkey   = 1'b0;
        nbusy  = 1'b0;
        ndone  = 1'b0;
        nerr   = 1'b0;
        case (state)
            INIT: begin
                // cnt==0 marks the first edge after reset: force the line off
                if (cnt == '0) begin
                    ncnt  = CW'(1);
                    nk    = 1'b1;
                    nbusy = 1'b1;
                end else begin
                    nstate = IDLE;
                    ncnt   = '0;
                end
            end
            IDLE: begin
                if (START) begin
                    if (rom_ok) begin
                        nstate = MARK;
                        npat   = rom_pat;
                        nidx   = first_idx;
                        ncnt   = rom_pat[first_idx] ? DASH_LD : DOT_LD;
                        nj     = 1'b1;
                        nkey   = 1'b1;
                        nbusy  = 1'b1;
                    end else begin
                        nerr = 1'b1;
                    end
                end
            end
            MARK: begin
                nbusy = 1'b1;
                if (cnt == '0) begin
                    nk = 1'b1;
                    if (idx != 2'd0) begin
                        nstate = SPACE;
                        ncnt   = DOT_LD;
                    end else begin
                        nstate = CGAP;
                        ncnt   = DASH_LD;
                    end
                end else begin
                    ncnt = cnt - CW'(1);
                    nkey = 1'b1;
                end
            end
            SPACE: begin
                nbusy = 1'b1;
                if (cnt == '0) begin
                    nstate = MARK;
                    nidx   = prev_idx;
                    ncnt   = pat[prev_idx] ? DASH_LD : DOT_LD;
                    nj     = 1'b1;
                    nkey   = 1'b1;
                end else begin
                    ncnt = cnt - CW'(1);
                end
            end
            CGAP: begin
                if (cnt == '0) begin
                    nstate = IDLE;
                    ncnt   = '0;
                    ndone  = 1'b1;
                end else begin
                    ncnt  = cnt - CW'(1);
                    nbusy = 1'b1;
                end
            end
            default: begin
                nstate = INIT;
                ncnt   = '0;
            end
        endcase
    end

    // State, counters and registered outputs; reset clears every output at once
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= INIT;
            cnt   <= '0;
            idx   <= 2'd0;
            pat   <= 4'd0;
            J     <= 1'b0;
            K     <= 1'b0;
            KEY   <= 1'b0;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
            ERR   <= 1'b0;
        end else begin
            state <= nstate;
            cnt   <= ncnt;
            idx   <= nidx;
            pat   <= npat;
            J     <= nj;
            K     <= nk;
            KEY   <= nkey;
            BUSY  <= nbusy;
            DONE  <= ndone;
            ERR   <= nerr;
        end
    end

endmodule
